// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus arbiter: FSM encoding,
// HD44780 command constants and the power-on init command table.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0E;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

  localparam logic [2:0] INIT_LEN = 3'd5;

  // Init bytes in the order the controller expects them after power-up.
  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = LCD_CMD_FUNCSET;
      3'd1:    cmd = LCD_CMD_DISPON;
      3'd2:    cmd = LCD_CMD_ENTRY;
      3'd3:    cmd = LCD_CMD_HOME;
      default: cmd = LCD_CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Clear and home are the slow commands; they need the extended settle time.
  function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
    return !rs && (data <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational one-hot grant from a request vector; fixed priority
// (index 0 highest) or round-robin starting at the supplied pointer.
module lcd_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter bit RR_EN = 1'b0,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o
);

  // Two passes: first requesters at or above the start index, then wrap.
  always_comb begin
    int   start;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    start   = RR_EN ? int'(ptr_i) : 0;
    if (start >= NREQ) start = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (i >= start)) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780 bus owner: runs the init sequence, then serves one requester byte at
// a time with setup/EN/hold timing. Define LCD_ARB_RR_EN for round-robin grant.
module lcd_bus_arbiter import lcd_pkg::*; #(
  parameter int          NREQ   = 2,
  parameter logic [15:0] T_PWR  = 16'd20000,
  parameter logic [15:0] T_SU   = 16'd200,
  parameter logic [15:0] T_EN   = 16'd1600,
  parameter logic [15:0] T_HOLD = 16'd200,
  parameter logic [15:0] T_LONG = 16'd4000
) (
  input  logic                LCDCLK,
  input  logic                PRESET,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_rs,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     gnt,
  output logic                init_done,
  output logic                busy,
  output logic                LCD_RS,
  output logic                LCD_RW,
  output logic                LCD_EN,
  output logic [7:0]          LCD_DATA
);

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;

  lcd_state_e        state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic [2:0]        initIdx_q, initIdx_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d;
  logic              en_q, en_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              initDone_q, initDone_d;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  ptr;
  logic              accept;
  logic              timerDone;
  logic              pwrDone;
  logic [7:0]        selData;
  logic              selRs;

`ifdef LCD_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic [PTR_W-1:0] ptr_q, ptr_d, winIdx;

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) winIdx = PTR_W'(i);
    end
    ptr_d = ptr_q;
    if (accept) ptr_d = (winIdx == PTR_W'(NREQ - 1)) ? '0 : winIdx + PTR_W'(1);
  end

  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  localparam bit RR_EN = 1'b0;
  assign ptr = '0;
`endif

  lcd_rr_arbiter #(
    .NREQ  (NREQ),
    .RR_EN (RR_EN),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr),
    .grant_o (grant)
  );

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign timerDone = (timer_q == 16'd0);
  // The power-on wait counts up from the reset value; every other state
  // loads its duration on entry and counts down to zero.
  assign pwrDone   = (timer_q == T_PWR - 16'd1);

  always_comb begin
    selData = '0;
    selRs   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selData = selData | req_data[8*i +: 8];
        selRs   = selRs | req_rs[i];
      end
    end
  end

  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) state_q <= PWR_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PWR_WAIT: if (pwrDone)   state_d = SETUP;
      IDLE:     if (accept)    state_d = SETUP;
      SETUP:    if (timerDone) state_d = PULSE;
      PULSE:    if (timerDone) state_d = HOLD;
      HOLD:     if (timerDone) state_d = (initIdx_q < INIT_LEN) ? SETUP : IDLE;
      default:                 state_d = PWR_WAIT;
    endcase
  end

  always_comb begin
    req_ready = accept ? grant : '0;
    busy      = (state_q != IDLE);
  end

  // Bus registers only move on entry to SETUP, so DATA/RS are stable for the
  // whole strobe and hold window.
  always_comb begin
    timer_d    = timer_q;
    initIdx_d  = initIdx_q;
    data_d     = data_q;
    rs_d       = rs_q;
    gnt_d      = gnt_q;
    en_d       = (state_d == PULSE);
    initDone_d = initDone_q | (state_d == IDLE);

    if (state_d != state_q) begin
      case (state_d)
        SETUP:   timer_d = T_SU - 16'd1;
        PULSE:   timer_d = T_EN - 16'd1;
        HOLD:    timer_d = isLongCmd(rs_q, data_q) ? (T_HOLD + T_LONG - 16'd1)
                                                   : (T_HOLD - 16'd1);
        default: timer_d = 16'd0;
      endcase
    end else if (state_q == PWR_WAIT) begin
      timer_d = timer_q + 16'd1;
    end else if (!timerDone) begin
      timer_d = timer_q - 16'd1;
    end

    if (accept) begin
      data_d = selData;
      rs_d   = selRs;
      gnt_d  = grant;
    end else if ((state_d == SETUP) && ((state_q == PWR_WAIT) || (state_q == HOLD))) begin
      data_d    = initCmd(initIdx_q);
      rs_d      = 1'b0;
      initIdx_d = initIdx_q + 3'd1;
    end

    if ((state_q == HOLD) && (state_d == IDLE)) gnt_d = '0;
  end

  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) begin
      timer_q    <= 16'd0;
      initIdx_q  <= 3'd0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      gnt_q      <= '0;
      initDone_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      initIdx_q  <= initIdx_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      gnt_q      <= gnt_d;
      initDone_q <= initDone_d;
    end
  end

  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;
  assign LCD_DATA  = data_q;
  assign gnt       = gnt_q;
  assign init_done = initDone_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened timing parameters:
// init sequence, single and contended transactions, long-command gaps, reset.
module tb_lcd_bus_arbiter;

  localparam int NREQ = 2;
  // T_PWR=20, T_SU=3, T_EN=5, T_HOLD=4, T_LONG=10
  localparam int TXN_GAP  = 13;
  localparam int LONG_GAP = 23;
  localparam int INIT_DONE_K = 100;
  localparam int INIT_RISE [5] = '{23, 35, 47, 59, 81};
  localparam logic [7:0] INIT_DATA [5] = '{8'h38, 8'h0E, 8'h06, 8'h02, 8'h01};
`ifdef LCD_ARB_RR_EN
  localparam int B_FIRST = 1;
  localparam int C_EXP [4] = '{1, 0, 1, 0};
`else
  localparam int B_FIRST = 0;
  localparam int C_EXP [4] = '{0, 0, 0, 0};
`endif

  logic              LCDCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_rs = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready, gnt;
  logic              init_done, busy, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0]        LCD_DATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 LCDCLK = ~LCDCLK;

  always @(posedge LCDCLK) cyc <= cyc + 1;

  lcd_bus_arbiter #(
    .NREQ   (NREQ),
    .T_PWR  (16'd20),
    .T_SU   (16'd3),
    .T_EN   (16'd5),
    .T_HOLD (16'd4),
    .T_LONG (16'd10)
  ) dut (
    .LCDCLK    (LCDCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .init_done (init_done),
    .busy      (busy),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_EN    (LCD_EN),
    .LCD_DATA  (LCD_DATA)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic rs, input logic [7:0] data);
    req_rs[idx]          = rs;
    req_data[8*idx +: 8] = data;
    req_valid[idx]       = 1'b1;
  endtask

  task automatic waitAccept(input string tag, input bit keep, output int who, output int at);
    who = -1;
    at  = -1;
    for (int n = 0; n < 400 && at < 0; n++) begin
      @(negedge LCDCLK);
      if (req_ready != '0) begin
        at = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) who = i;
      end
    end
    checkOutput({tag, " accept seen"}, 32'(at >= 0), 32'd1);
    if (at >= 0) begin
      checkOutput({tag, " ready onehot"}, 32'($countones(req_ready)), 32'd1);
      @(posedge LCDCLK);
      #1;
      if (!keep) req_valid[who] = 1'b0;
    end
  endtask

  task automatic observeTxn(input string tag, input int at, input logic [7:0] expData,
                            input logic expRs, input logic [NREQ-1:0] expGnt);
    int enCnt = 0, enFirst = -1, busBad = 0, gntBad = 0, readyBad = 0;
    for (int o = 1; o < TXN_GAP; o++) begin
      @(negedge LCDCLK);
      if (LCD_EN) begin
        enCnt++;
        if (enFirst < 0) enFirst = cyc - at;
      end
      if (LCD_DATA !== expData || LCD_RS !== expRs) busBad++;
      if (gnt !== expGnt) gntBad++;
      if (req_ready !== '0) readyBad++;
    end
    checkOutput({tag, " en width"}, 32'(enCnt), 32'd5);
    checkOutput({tag, " en start"}, 32'(enFirst), 32'd4);
    checkOutput({tag, " bus stable"}, 32'(busBad), 32'd0);
    checkOutput({tag, " gnt"}, 32'(gntBad), 32'd0);
    checkOutput({tag, " no ready"}, 32'(readyBad), 32'd0);
  endtask

  // Called right after PRESET is released on a falling edge.
  task automatic checkInit(input string tag);
    int rises [5];
    logic [7:0] datas [5];
    int nR = 0, enCnt = 0, rsBad = 0, readyBad = 0, gntBad = 0, doneAt = -1;
    logic prevEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rises[i] = -1;
      datas[i] = 8'h00;
    end
    for (int k = 1; k <= 200 && doneAt < 0; k++) begin
      @(negedge LCDCLK);
      if (k == 90) req_valid = '0;
      if (LCD_EN && !prevEn) begin
        if (nR < 5) begin
          rises[nR] = k;
          datas[nR] = LCD_DATA;
        end
        nR++;
      end
      if (LCD_EN) begin
        enCnt++;
        if (LCD_RS) rsBad++;
      end
      if (req_ready !== '0) readyBad++;
      if (gnt !== '0) gntBad++;
      if (init_done) doneAt = k;
      prevEn = LCD_EN;
    end
    checkOutput({tag, " pulse count"}, 32'(nR), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("%s rise %0d", tag, i), 32'(rises[i]), 32'(INIT_RISE[i]));
      checkOutput($sformatf("%s data %0d", tag, i), 32'(datas[i]), 32'(INIT_DATA[i]));
    end
    checkOutput({tag, " en cycles"}, 32'(enCnt), 32'd25);
    checkOutput({tag, " rs low"}, 32'(rsBad), 32'd0);
    checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(INIT_DONE_K));
    checkOutput({tag, " no ready"}, 32'(readyBad), 32'd0);
    checkOutput({tag, " no gnt"}, 32'(gntBad), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic gapTest(input string tag, input logic rs, input logic [7:0] data, input int expGap);
    int w0, t0, w1, t1;
    applyStimulus(0, rs, data);
    waitAccept({tag, " first"}, 1'b0, w0, t0);
    applyStimulus(1, 1'b1, 8'h55);
    waitAccept({tag, " second"}, 1'b0, w1, t1);
    checkOutput({tag, " gap"}, 32'(t1 - t0), 32'(expGap));
  endtask

  initial begin
    int w, t0, t1;

    // Reset state
    @(negedge LCDCLK);
    @(negedge LCDCLK);
    checkOutput("rst EN", 32'(LCD_EN), 32'd0);
    checkOutput("rst RS", 32'(LCD_RS), 32'd0);
    checkOutput("rst RW", 32'(LCD_RW), 32'd0);
    checkOutput("rst DATA", 32'(LCD_DATA), 32'd0);
    checkOutput("rst ready", 32'(req_ready), 32'd0);
    checkOutput("rst gnt", 32'(gnt), 32'd0);
    checkOutput("rst init_done", 32'(init_done), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd1);
    applyStimulus(1, 1'b1, 8'h5A);
    PRESET = 1'b0;
    checkInit("init");

    // Single character from requester 0
    applyStimulus(0, 1'b1, 8'h41);
    waitAccept("A", 1'b0, w, t0);
    checkOutput("A winner", 32'(w), 32'd0);
    observeTxn("A", t0, 8'h41, 1'b1, 2'b01);
    @(negedge LCDCLK);
    checkOutput("A idle busy", 32'(busy), 32'd0);
    checkOutput("A idle gnt", 32'(gnt), 32'd0);

    // Contention: both requesters at once
    applyStimulus(0, 1'b0, 8'h80);
    applyStimulus(1, 1'b1, 8'h42);
    waitAccept("B1", 1'b0, w, t0);
    checkOutput("B1 winner", 32'(w), 32'(B_FIRST));
    observeTxn("B1", t0, (B_FIRST == 1) ? 8'h42 : 8'h80, (B_FIRST == 1) ? 1'b1 : 1'b0,
               (B_FIRST == 1) ? 2'b10 : 2'b01);
    waitAccept("B2", 1'b0, w, t1);
    checkOutput("B2 winner", 32'(w), 32'(1 - B_FIRST));
    checkOutput("B2 gap", 32'(t1 - t0), 32'(TXN_GAP));

    // Both held continuously
    applyStimulus(0, 1'b1, 8'h30);
    applyStimulus(1, 1'b1, 8'h31);
    for (int n = 0; n < 4; n++) begin
      waitAccept($sformatf("C%0d", n), 1'b1, w, t1);
      checkOutput($sformatf("C%0d winner", n), 32'(w), 32'(C_EXP[n]));
      if (n > 0) checkOutput($sformatf("C%0d gap", n), 32'(t1 - t0), 32'(TXN_GAP));
      t0 = t1;
    end
    req_valid = '0;

    // Long-settle boundary cases
    gapTest("clear", 1'b0, 8'h01, LONG_GAP);
    gapTest("home", 1'b0, 8'h02, LONG_GAP);
    gapTest("cmd03", 1'b0, 8'h03, LONG_GAP);
    gapTest("cmd04", 1'b0, 8'h04, TXN_GAP);
    gapTest("char01", 1'b1, 8'h01, TXN_GAP);
    gapTest("line1", 1'b0, 8'h80, TXN_GAP);

    // Reset in the middle of the EN pulse
    applyStimulus(0, 1'b1, 8'h33);
    waitAccept("R", 1'b0, w, t0);
    for (int o = 1; o <= 6; o++) @(negedge LCDCLK);
    checkOutput("R en before", 32'(LCD_EN), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("R en drop", 32'(LCD_EN), 32'd0);
    checkOutput("R init_done", 32'(init_done), 32'd0);
    checkOutput("R busy", 32'(busy), 32'd1);
    checkOutput("R gnt", 32'(gnt), 32'd0);
    checkOutput("R data", 32'(LCD_DATA), 32'd0);
    @(negedge LCDCLK);
    @(negedge LCDCLK);
    applyStimulus(1, 1'b1, 8'h5B);
    PRESET = 1'b0;
    checkInit("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
